// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-side endpoint for ALU LOAD/STORE ops. Latches the access on an
//   enable pulse in IDLE and runs one req/ack transaction on the data-memory
//   bus. Loads return the byte/halfword/word picked from the read word,
//   sign- or zero-extended. Only one access is in flight; enable while busy
//   is dropped.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned LH/LHU/SH/LW/SW skip the bus and complete with
//                 misaligned=1 (load_data untouched)
//     undefined : misaligned tied 0, offending low address bits are ignored
//
// Ports
//   clk, rst            clock / synchronous active-high reset
//   enable              start pulse (sampled only in IDLE)
//   is_store, funct3    access kind and RV32I size field
//   addr, store_data    byte address and rs2 value
//   busy, done          not-IDLE flag / one-cycle completion pulse
//   load_data           extended load result, held until the next done
//   misaligned          pulses with done on a trapped misaligned access
//   mem_req/we/addr/be/wdata   registered bus request, zero outside REQ
//   mem_rdata, mem_ack  responder read word and completion
module load_store_unit #(
  parameter int XLEN        = 32,  // must be 32: four byte lanes are fixed
  parameter int FUNCT3_SIZE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   is_store,
  input  logic [FUNCT3_SIZE-1:0] funct3,
  input  logic [XLEN-1:0]        addr,
  input  logic [XLEN-1:0]        store_data,
  output logic                   busy,
  output logic                   done,
  output logic [XLEN-1:0]        load_data,
  output logic                   misaligned,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [XLEN-1:0]        mem_addr,
  output logic [3:0]             mem_be,
  output logic [XLEN-1:0]        mem_wdata,
  input  logic [XLEN-1:0]        mem_rdata,
  input  logic                   mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [FUNCT3_SIZE-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_SIZE-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_SIZE-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_SIZE-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_SIZE-1:0] F3_HU = 3'b101;

  // What the load extractor needs once the ack arrives
  typedef struct packed {
    logic [FUNCT3_SIZE-1:0] funct3;
    logic [1:0]             off;
  } acc_t;

  state_e          state_q, state_d;
  acc_t            acc_q, acc_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic            mis_q, mis_d;

  logic            legal;
  logic            mis_det;
  logic [1:0]      size;
  logic [1:0]      off_eff;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_ext;

  assign size = funct3[1:0];

  // Unsigned variants exist only for loads; 011/110/111 are never legal
  always_comb begin
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !is_store;
      default:          legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_det = ((size == 2'b01) && addr[0]) ||
                   ((size == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign mis_det = 1'b0;
`endif

  // Lane offset actually used: halfwords only look at addr[1], words are
  // always lane 0, so misaligned addresses are silently rounded down.
  always_comb begin
    case (size)
      2'b00:   off_eff = addr[1:0];
      2'b01:   off_eff = {addr[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

  always_comb begin
    case (size)
      2'b00:   be_new = 4'b0001 << off_eff;
      2'b01:   be_new = 4'b0011 << off_eff;
      default: be_new = 4'b1111;
    endcase
  end

  // Replicate the store value on every lane; byte enables pick the target
  always_comb begin
    case (size)
      2'b00:   wdata_new = {4{store_data[7:0]}};
      2'b01:   wdata_new = {2{store_data[15:0]}};
      default: wdata_new = store_data;
    endcase
  end

  assign lane = mem_rdata >> {acc_q.off, 3'b000};

  always_comb begin
    case (acc_q.funct3)
      F3_B:    ld_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_H:    ld_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_BU:   ld_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_HU:   ld_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: ld_ext = lane;  // word: offset is always 0
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    req_d   = 1'b0;
    we_d    = 1'b0;
    maddr_d = '0;
    be_d    = '0;
    wdata_d = '0;
    ld_d    = ld_q;
    mis_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (!legal) begin
            state_d = S_DONE;
            ld_d    = '0;
          end else if (mis_det) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end else begin
            state_d      = S_REQ;
            req_d        = 1'b1;
            we_d         = is_store;
            maddr_d      = {addr[XLEN-1:2], 2'b00};
            be_d         = be_new;
            wdata_d      = is_store ? wdata_new : '0;
            acc_d.funct3 = funct3;
            acc_d.off    = off_eff;
          end
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
          if (!we_q) ld_d = ld_ext;
        end else begin
          // Hold the request bit-for-bit until the responder acks
          req_d   = req_q;
          we_d    = we_q;
          maddr_d = maddr_q;
          be_d    = be_q;
          wdata_d = wdata_q;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign load_data  = ld_q;
  assign misaligned = mis_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;

endmodule
